// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - shared types, constants and bit helpers for the CRC-32 frame sequencer
package crc32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_RESULT = 2'd3
    } crc_state_t;

    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_CHECK  = 32'hCBF4_3926;
    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // One byte through the MSB-first CRC-32 polynomial, data bit 7 first.
    function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/next_crc32_d8.sv
// rtl/next_crc32_d8.sv - byte-wide CRC-32 engine with a one-cycle registered result
module next_crc32_d8
    import crc32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [7:0]  data,
    input  logic [31:0] crc,
    output logic [31:0] return_port,
    output logic        done_port
);

    // Free-running: the result register tracks crc/data every cycle, done marks real issues.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            return_port <= 32'h0;
            done_port   <= 1'b0;
        end else begin
            return_port <= crc32_step8(crc, data);
            done_port   <= start_port;
        end
    end

endmodule

// File: rtl/crc32_frame_ctrl.sv
// rtl/crc32_frame_ctrl.sv - two-requester round-robin frame sequencer for the shared CRC-32 engine
module crc32_frame_ctrl
    import crc32_pkg::*;
#(
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] XOROUT  = CRC32_XOROUT,
    parameter bit          REFLECT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_crc,
    output logic [15:0] res_len,
    output logic        res_id
);

    crc_state_t  state_q, state_d;
    logic        g_q;
    logic        last_served_q;
    logic        first_q;
    logic        issued_q;
    logic [31:0] crc_q;
    logic [15:0] len_q;
    logic [31:0] res_crc_q;
    logic [15:0] res_len_q;
    logic        res_id_q;

    logic        grant_d;
    logic        issue;
    logic [7:0]  cur_byte;
    logic [7:0]  eng_data;
    logic [31:0] eng_crc;
    logic [31:0] eng_ret;
    logic [31:0] fin_crc;
    logic        eng_done_unused;

    // Round-robin choice among currently valid requesters.
    always_comb begin
        grant_d = 1'b0;
        if (req_valid == 2'b11) begin
            grant_d = ~last_served_q;
        end else if (req_valid[1]) begin
            grant_d = 1'b1;
        end
    end

    assign issue    = (state_q == ST_STREAM) && req_valid[g_q];
    assign cur_byte = g_q ? req_data[15:8] : req_data[7:0];
    assign eng_data = REFLECT ? bitrev8(cur_byte) : cur_byte;

    // Feedback select: seed on the first byte, live result right after an issue, held copy after bubbles.
    always_comb begin
        eng_crc = crc_q;
        if (first_q) begin
            eng_crc = INIT;
        end else if (issued_q) begin
            eng_crc = eng_ret;
        end
    end

    assign fin_crc = (REFLECT ? bitrev32(eng_ret) : eng_ret) ^ XOROUT;

    next_crc32_d8 u_engine (
        .clock       (clock),
        .reset       (reset),
        .start_port  (issue),
        .data        (eng_data),
        .crc         (eng_crc),
        .return_port (eng_ret),
        .done_port   (eng_done_unused)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: whole frames are granted, results must be consumed before the next grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue && req_last[g_q]) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded only from registered state.
    always_comb begin
        req_ready = 2'b00;
        res_valid = 1'b0;
        if (state_q == ST_STREAM) begin
            req_ready = g_q ? 2'b10 : 2'b01;
        end
        if (state_q == ST_RESULT) begin
            res_valid = 1'b1;
        end
    end

    // Frame datapath: grant latch, CRC hold register, byte count and result capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            g_q           <= 1'b0;
            last_served_q <= 1'b1;
            first_q       <= 1'b0;
            issued_q      <= 1'b0;
            crc_q         <= 32'h0;
            len_q         <= 16'h0;
            res_crc_q     <= 32'h0;
            res_len_q     <= 16'h0;
            res_id_q      <= 1'b0;
        end else begin
            issued_q <= issue;
            if (issued_q) begin
                crc_q <= eng_ret;
            end
            if ((state_q == ST_IDLE) && (|req_valid)) begin
                g_q     <= grant_d;
                first_q <= 1'b1;
                len_q   <= 16'h0;
            end
            if (issue) begin
                first_q <= 1'b0;
                len_q   <= len_q + 16'd1;
            end
            if (state_q == ST_FLUSH) begin
                res_crc_q     <= fin_crc;
                res_len_q     <= len_q;
                res_id_q      <= g_q;
                last_served_q <= g_q;
            end
        end
    end

    assign res_crc = res_crc_q;
    assign res_len = res_len_q;
    assign res_id  = res_id_q;

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// tb/tb_crc32_frame_ctrl.sv - self-checking bench for crc32_frame_ctrl
module tb_crc32_frame_ctrl;
    import crc32_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_crc;
    logic [15:0] res_len;
    logic        res_id;

    always #5 clock = ~clock;

    crc32_frame_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_len   (res_len),
        .res_id    (res_id)
    );

    typedef struct {
        logic [31:0] crc;
        logic [15:0] len;
        logic        id;
    } exp_t;

    typedef struct {
        int           id;
        logic [127:0] d;
        int           len;
        bit           bub;
        bit           use_model;
        logic [31:0]  crc;
    } vec_t;

    exp_t sb_q[$];
    logic ids_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   rise_cyc = 0;
    int   other_ready_hits = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC-32 in the reflected LSB-first form.
    function automatic logic [31:0] model_crc(input logic [127:0] d, input int len);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < len; k++) begin
            c = c ^ {24'h0, d[k*8 +: 8]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Result monitor: pops the scoreboard on each result handshake.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (res_valid && !prev) rise_cyc = cyc;
            prev = res_valid;
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got crc %h with no frame expected", res_crc);
                end else begin
                    e = sb_q.pop_front();
                    check("res_crc", res_crc, e.crc);
                    check("res_len", {16'h0, res_len}, {16'h0, e.len});
                    check("res_id", {31'h0, res_id}, {31'h0, e.id});
                    ids_q.push_back(res_id);
                end
            end
        end
    end

    task automatic send_frame(input int id, input logic [127:0] d, input int len,
                              input bit bub, input logic [31:0] exp_crc);
        int   k;
        int   budget;
        bit   started;
        exp_t e;
        k = 0;
        started = 1'b0;
        while (k < len) begin
            if (bub && k > 0) begin
                int n;
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    @(negedge clock);
                    req_valid[id] = 1'b0;
                end
            end
            budget = 0;
            forever begin
                @(negedge clock);
                req_valid[id] = 1'b1;
                req_data[id*8 +: 8] = d[k*8 +: 8];
                req_last[id] = (k == len - 1);
                if (started && req_ready[id ^ 1]) other_ready_hits++;
                if (req_ready[id]) break;
                budget++;
                if (budget > 300) begin
                    total++;
                    bad++;
                    $display("FAIL grant_timeout: requester %0d got no ready, expected ready", id);
                    req_valid[id] = 1'b0;
                    req_last[id] = 1'b0;
                    return;
                end
            end
            if (!started) begin
                e.crc = exp_crc;
                e.len = len[15:0];
                e.id  = id[0];
                sb_q.push_back(e);
                started = 1'b1;
            end
            if (k == len - 1) last_acc_cyc = cyc;
            k++;
        end
        @(negedge clock);
        req_valid[id] = 1'b0;
        req_last[id] = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb_q.size() != 0 || res_valid) && budget < 300) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb_q.size());
        end
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_valid"}, {31'h0, res_valid}, 32'h0);
        check({tag, "_res_crc"}, res_crc, 32'h0);
        check({tag, "_res_len"}, {16'h0, res_len}, 32'h0);
        check({tag, "_res_id"}, {31'h0, res_id}, 32'h0);
        check({tag, "_req_ready"}, {30'h0, req_ready}, 32'h0);
    endtask

    vec_t         tbl[5];
    logic [127:0] digits;
    logic [127:0] ones;
    logic [127:0] rnd;
    logic [127:0] fa;
    logic [127:0] fb;
    logic [127:0] fc;
    logic [31:0]  exp_crc;

    initial begin
        req_valid = 2'b00;
        req_data  = 16'h0;
        req_last  = 2'b00;
        res_ready = 1'b1;

        digits = '0;
        ones   = '0;
        rnd    = '0;
        for (int k = 0; k < 9; k++) digits[k*8 +: 8] = 8'h31 + k[7:0];
        for (int k = 0; k < 16; k++) ones[k*8 +: 8] = 8'hFF;
        for (int k = 0; k < 7; k++) rnd[k*8 +: 8] = 8'($urandom);
        fa = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
        fb = 128'h0000_0000_0000_0000_0000_0000_0102_0304;
        fc = 128'h0000_0000_0000_0000_0000_0000_A5C3_3C5A;

        tbl[0] = '{id: 0, d: digits, len: 9,  bub: 1'b0, use_model: 1'b0, crc: 32'hCBF4_3926};
        tbl[1] = '{id: 1, d: digits, len: 9,  bub: 1'b1, use_model: 1'b0, crc: 32'hCBF4_3926};
        tbl[2] = '{id: 0, d: '0,     len: 1,  bub: 1'b0, use_model: 1'b0, crc: 32'hD202_EF8D};
        tbl[3] = '{id: 1, d: rnd,    len: 7,  bub: 1'b1, use_model: 1'b1, crc: 32'h0};
        tbl[4] = '{id: 0, d: ones,   len: 16, bub: 1'b0, use_model: 1'b1, crc: 32'h0};

        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            exp_crc = tbl[i].use_model ? model_crc(tbl[i].d, tbl[i].len) : tbl[i].crc;
            send_frame(tbl[i].id, tbl[i].d, tbl[i].len, tbl[i].bub, exp_crc);
            drain();
            if (i == 0) check("res_latency", rise_cyc - last_acc_cyc, 32'd2);
        end

        // Both requesters contend from reset: grants must alternate.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        ids_q.delete();
        other_ready_hits = 0;
        fork
            begin
                send_frame(0, fa, 4, 1'b0, model_crc(fa, 4));
                send_frame(0, fb, 4, 1'b0, model_crc(fb, 4));
            end
            begin
                send_frame(1, fb, 4, 1'b0, model_crc(fb, 4));
                send_frame(1, fa, 4, 1'b0, model_crc(fa, 4));
            end
        join
        drain();
        check("alt_count", ids_q.size(), 32'd4);
        for (int k = 0; k < ids_q.size(); k++) begin
            check("alt_order", {31'h0, ids_q[k]}, k % 2);
        end
        check("other_ready", other_ready_hits, 32'd0);

        // Result back-pressure: output held and no new grant.
        res_ready = 1'b0;
        send_frame(0, fc, 4, 1'b0, model_crc(fc, 4));
        fork
            send_frame(1, '0, 1, 1'b0, 32'hD202_EF8D);
            begin
                int budget;
                budget = 0;
                while (!res_valid && budget < 20) begin
                    @(negedge clock);
                    budget++;
                end
                for (int k = 0; k < 10; k++) begin
                    @(negedge clock);
                    check("stall_valid", {31'h0, res_valid}, 32'h1);
                    check("stall_crc", res_crc, model_crc(fc, 4));
                    check("stall_ready", {30'h0, req_ready}, 32'h0);
                end
                res_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a frame, then a clean resend.
        begin
            int k;
            int budget;
            k = 0;
            budget = 0;
            while (k < 3 && budget < 50) begin
                @(negedge clock);
                req_valid[0] = 1'b1;
                req_data[7:0] = 8'h31 + k[7:0];
                req_last[0] = 1'b0;
                if (req_ready[0]) k++;
                budget++;
            end
            check("partial_bytes", k, 32'd3);
        end
        @(negedge clock);
        reset = 1'b0;
        req_valid = 2'b00;
        #1;
        check_reset_outputs("midreset");
        @(negedge clock);
        reset = 1'b1;
        send_frame(0, digits, 9, 1'b0, CRC32_CHECK);
        drain();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc32_frame_ctrl.md
# crc32_frame_ctrl

Sequencer and arbiter for the shared byte-wide CRC-32 engine `next_crc32_d8`. It accepts byte streams from two requesters over valid/ready, grants the engine to one whole frame at a time using round-robin arbitration, and feeds one byte per cycle with correct CRC feedback. For each frame it returns the finalised CRC-32 (zlib/Ethernet convention), the byte count and the requester ID. It sits between the XVC packet handlers and the single CRC engine instance.

## Interface
- `INIT`, 32'hFFFF_FFFF, CRC seed applied to the first byte of each frame
- `XOROUT`, 32'hFFFF_FFFF, value XORed into the final CRC
- `REFLECT`, 1, when 1: bit-reverse each input byte before the engine and bit-reverse the final CRC before `XOROUT`
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester byte valid
- `req_data`  in  16  byte of requester i at bits [8i+7:8i]
- `req_last`  in  2  marks the final byte of a frame
- `req_ready`  out  2  byte accepted when `req_valid[i] & req_ready[i]`
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid & res_ready`
- `res_crc`  out  32  final CRC of the frame
- `res_len`  out  16  bytes in the frame, wraps modulo 2^16
- `res_id`  out  1  requester that owned the frame

## Operation
- States: IDLE, STREAM, FLUSH, RESULT. Reset state is IDLE. On reset, all outputs are 0 and `last_served` is 1.
- IDLE:
  - `req_ready` = 0.
  - If any `req_valid` is high, latch grant `g` and go to STREAM.
  - With both requesters valid, `g` = !`last_served`. With one valid, `g` = that requester.
- STREAM:
  - `req_ready[g]` = 1; the other requester's ready is 0.
  - Each accepted byte goes to the engine: `data` = `REFLECT` ? bitrev(byte) : byte.
  - Engine `crc` input is selected as follows:
    - `INIT` for the first byte of the frame;
    - the engine's `return_port` if a byte was issued in the previous cycle;
    - otherwise the held register `crc_q`.
  - `crc_q` captures `return_port` one cycle after each issue.
  - `len_q` increments on each accepted byte.
  - Bubbles (`req_valid[g]` low) stall without corrupting `crc_q`; the engine's free-running register is ignored during bubbles.
  - An accepted byte with `req_last` moves the FSM to FLUSH.
- FLUSH:
  - One cycle. `return_port` now holds the CRC of the last byte.
  - Register `res_crc` = (`REFLECT` ? bitrev32(`return_port`) : `return_port`) ^ `XOROUT`.
  - Register `res_len` and `res_id` = `g`; set `last_served` = `g`; go to RESULT.
- RESULT:
  - `res_valid` = 1. `res_crc`, `res_len` and `res_id` hold stable until the handshake.
  - On `res_ready`, clear `res_valid` and go to IDLE.
  - No new frame is granted while a result is pending.
- Zero-length frames do not exist: `req_last` always accompanies a real byte.
- `req_last` from a non-granted requester is ignored; it never sees ready.
- Engine hookup: `start_port` is tied to the issue strobe. `done_port` is unused, because engine latency is fixed at 1 cycle.
- Reset asserted mid-frame: the FSM returns to IDLE and the partial frame is discarded. The requester must restart the frame.

## Timing
- IDLE to STREAM costs 1 arbitration cycle. The first byte can be accepted in the cycle after the grant.
- Throughput is 1 byte per cycle in STREAM.
- Last byte accepted at cycle t: FLUSH at t+1, `res_valid` high at t+2.
- Earliest next grant is the cycle after the `res_ready` handshake (IDLE), so the gap between frames is at least 2 cycles plus the result-wait time.
- `req_ready` and `res_valid` are decoded from registered state only, with no combinational path from inputs.

## Structure
- Package `crc32_pkg` holds:
  - state enum `crc_state_t`;
  - constants `CRC32_INIT`, `CRC32_XOROUT` and `CRC32_CHECK` = 32'hCBF4_3926;
  - functions `bitrev8` and `bitrev32`.
- One sub-module: a single instance of `next_crc32_d8`. The arbiter, feedback mux and FSM are inline.

## Test plan
- Requester 0 sends "123456789" (0x31…0x39) back-to-back -> `res_crc` = 0xCBF43926, `res_len` = 9, `res_id` = 0, `res_valid` rising 2 cycles after the last byte.
- Same frame from requester 1 with random 1–3 cycle valid bubbles -> identical CRC 0xCBF43926 and `res_len` = 9.
- Single-byte frame 0x00 -> `res_crc` = 0xD202EF8D, `res_len` = 1.
- Both requesters hold valid from reset with 4-byte frames -> grants alternate 0,1,0,1; the non-granted `req_ready` stays 0 throughout each frame.
- `res_ready` held low for 10 cycles -> `res_valid` and `res_crc` stay stable; no requester is granted until the handshake.
- `reset` pulsed low mid-frame on requester 0, then "123456789" resent -> all outputs 0 during reset, then 0xCBF43926 with no stale state.
